// File: rtl/tlb_cam_unit.sv
// Dual-port lookup CAM for TLB tags: ENTRIES valid-qualified keys, lowest-index match wins.
// Optional macro TLB_CAM_INVALIDATE_EN adds an iEnable port that clears valid[writeAdr].
module tlb_cam_unit #(
    parameter int KEY_WIDTH = 36,
    parameter int ENTRIES   = 8,
    parameter int ADR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:KEY_WIDTH-1] patternA,
    input  logic [0:KEY_WIDTH-1] patternB,
    input  logic [ADR_WIDTH-1:0] writeAdr,
    input  logic                 wEnable,
`ifdef TLB_CAM_INVALIDATE_EN
    input  logic                 iEnable,
`endif
    output logic [ADR_WIDTH-1:0] matchAdrA,
    output logic [ADR_WIDTH-1:0] matchAdrB,
    output logic                 mFoundA,
    output logic                 mFoundB
);

    logic [0:KEY_WIDTH-1] key_q [ENTRIES];
    logic [0:KEY_WIDTH-1] key_d [ENTRIES];
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   valid_d;
    logic [ENTRIES-1:0]   hit_a;
    logic [ENTRIES-1:0]   hit_b;

    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        if (wEnable) begin
            key_d[writeAdr]   = patternA;
            valid_d[writeAdr] = 1'b1;
        end
`ifdef TLB_CAM_INVALIDATE_EN
        else if (iEnable) begin
            valid_d[writeAdr] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < ENTRIES; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    // Full-width compares; an invalid entry never hits, even on an all-zero key.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign hit_a[gi] = valid_q[gi] && (key_q[gi] == patternA);
            assign hit_b[gi] = valid_q[gi] && (key_q[gi] == patternB);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        matchAdrA = '0;
        matchAdrB = '0;
        mFoundA   = 1'b0;
        mFoundB   = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_a[i]) begin
                mFoundA   = 1'b1;
                matchAdrA = ADR_WIDTH'(i);
            end
            if (hit_b[i]) begin
                mFoundB   = 1'b1;
                matchAdrB = ADR_WIDTH'(i);
            end
        end
        if (rst) begin
            matchAdrA = '0;
            matchAdrB = '0;
            mFoundA   = 1'b0;
            mFoundB   = 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_cam_unit.sv
// Directed bench for tlb_cam_unit: reset, write/lookup, priority, no-bypass and async reset.
module tb_tlb_cam_unit;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:35]   patternA;
    logic [0:35]   patternB;
    logic [2:0]    writeAdr;
    logic          wEnable;
`ifdef TLB_CAM_INVALIDATE_EN
    logic          iEnable;
`endif
    logic [2:0]    matchAdrA;
    logic [2:0]    matchAdrB;
    logic          mFoundA;
    logic          mFoundB;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlb_cam_unit #(.KEY_WIDTH(36), .ENTRIES(8), .ADR_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .patternA  (patternA),
        .patternB  (patternB),
        .writeAdr  (writeAdr),
        .wEnable   (wEnable),
`ifdef TLB_CAM_INVALIDATE_EN
        .iEnable   (iEnable),
`endif
        .matchAdrA (matchAdrA),
        .matchAdrB (matchAdrB),
        .mFoundA   (mFoundA),
        .mFoundB   (mFoundB)
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic fa, input logic [2:0] aa,
                           input logic fb, input logic [2:0] ab);
        $display("lookup %s: A=%h B=%h -> fA=%0b aA=%0d fB=%0b aB=%0d",
                 tag, patternA, patternB, mFoundA, matchAdrA, mFoundB, matchAdrB);
        chk({tag, ".mFoundA"},   {35'd0, mFoundA},   {35'd0, fa});
        chk({tag, ".matchAdrA"}, {33'd0, matchAdrA}, {33'd0, aa});
        chk({tag, ".mFoundB"},   {35'd0, mFoundB},   {35'd0, fb});
        chk({tag, ".matchAdrB"}, {33'd0, matchAdrB}, {33'd0, ab});
    endtask

    task automatic look(input string tag, input logic [35:0] pa, input logic [35:0] pb,
                        input logic fa, input logic [2:0] aa, input logic fb, input logic [2:0] ab);
        patternA = pa;
        patternB = pb;
        #1;
        chk_out(tag, fa, aa, fb, ab);
    endtask

    task automatic do_write(input logic [35:0] k, input logic [2:0] a);
        @(negedge clk);
        patternA = k;
        writeAdr = a;
        wEnable  = 1'b1;
        @(negedge clk);
        wEnable  = 1'b0;
        $display("write entry %0d <= %h", a, k);
    endtask

    logic [35:0] keys [8];

    initial begin
        keys[0] = 36'h001200120; keys[1] = 36'h003400340;
        keys[2] = 36'h005600560; keys[3] = 36'h007800780;
        keys[4] = 36'h009A009A0; keys[5] = 36'h00BC00BC0;
        keys[6] = 36'h00DE00DE0; keys[7] = 36'h00FF00FF0;

        rst = 1'b1; wEnable = 1'b0; writeAdr = '0;
        patternA = '0; patternB = '0;
`ifdef TLB_CAM_INVALIDATE_EN
        iEnable = 1'b0;
`endif
        // Writes attempted while reset is held must be ignored.
        @(negedge clk);
        patternA = keys[4]; writeAdr = 3'd4; wEnable = 1'b1;
        @(negedge clk);
        wEnable = 1'b0;
        look("in_reset", 36'h0, 36'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        rst = 1'b0;
        @(negedge clk);
        look("after_reset_zero", 36'h0, 36'h0, 1'b0, 3'd0, 1'b0, 3'd0);
        look("write_in_reset_lost", keys[4], keys[4], 1'b0, 3'd0, 1'b0, 3'd0);

        for (int i = 0; i < 8; i++) begin
            do_write(keys[i], 3'(i));
        end
        look("hit_2_1", 36'h005600560, 36'h003400340, 1'b1, 3'd2, 1'b1, 3'd1);
        look("hit_3_0", 36'h007800780, 36'h001200120, 1'b1, 3'd3, 1'b1, 3'd0);
        look("partial_miss", 36'h000000780, 36'h001200000, 1'b0, 3'd0, 1'b0, 3'd0);
        look("hit_7_6", 36'h00FF00FF0, 36'h00DE00DE0, 1'b1, 3'd7, 1'b1, 3'd6);

        // No bypass: the key being written is only visible after the edge.
        @(negedge clk);
        patternA = 36'h0ABCDE123; patternB = 36'h0ABCDE123; writeAdr = 3'd5; wEnable = 1'b1;
        #1;
        chk_out("pre_edge_miss", 1'b0, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        chk_out("post_edge_hit5", 1'b1, 3'd5, 1'b1, 3'd5);
        @(negedge clk);
        writeAdr = 3'd2;
        #1;
        chk_out("pre_edge_dup_hit5", 1'b1, 3'd5, 1'b1, 3'd5);
        @(posedge clk);
        #1;
        chk_out("dup_lowest_2", 1'b1, 3'd2, 1'b1, 3'd2);
        @(negedge clk);
        wEnable = 1'b0;
        look("single_bit_miss", 36'h0ABCDE122, 36'h1ABCDE123, 1'b0, 3'd0, 1'b0, 3'd0);
        look("overwritten_miss", 36'h005600560, 36'h00BC00BC0, 1'b0, 3'd0, 1'b0, 3'd0);

`ifdef TLB_CAM_INVALIDATE_EN
        @(negedge clk);
        writeAdr = 3'd3; iEnable = 1'b1;
        @(negedge clk);
        iEnable = 1'b0;
        look("invalidated_miss", 36'h007800780, 36'h007800780, 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        patternA = 36'h007800780; writeAdr = 3'd3; wEnable = 1'b1; iEnable = 1'b1;
        @(negedge clk);
        wEnable = 1'b0; iEnable = 1'b0;
        look("write_wins", 36'h007800780, 36'h007800780, 1'b1, 3'd3, 1'b1, 3'd3);
`endif

        // wEnable low: nothing changes even though patternA/writeAdr move.
        @(negedge clk);
        patternA = 36'h111111111; writeAdr = 3'd0; wEnable = 1'b0;
        @(negedge clk);
        look("no_write", 36'h111111111, 36'h001200120, 1'b0, 3'd0, 1'b1, 3'd0);

        // Asynchronous reset mid-cycle clears hits without a clock edge.
        look("pre_async_rst", 36'h0ABCDE123, 36'h0ABCDE123, 1'b1, 3'd2, 1'b1, 3'd2);
        #1;
        rst = 1'b1;
        #1;
        chk_out("async_rst_now", 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        look("after_rst_cleared", 36'h0ABCDE123, 36'h001200120, 1'b0, 3'd0, 1'b0, 3'd0);

        // Reset rising inside a write cycle loses that write.
        do_write(36'h0CAFE0001, 3'd6);
        look("rewrite_hit6", 36'h0CAFE0001, 36'h0, 1'b1, 3'd6, 1'b0, 3'd0);
        @(negedge clk);
        patternA = 36'h0BEEF0002; writeAdr = 3'd1; wEnable = 1'b1;
        #2;
        rst = 1'b1;
        @(negedge clk);
        wEnable = 1'b0;
        rst = 1'b0;
        look("write_in_rst_lost", 36'h0BEEF0002, 36'h0CAFE0001, 1'b0, 3'd0, 1'b0, 3'd0);
        look("zero_after_rst", 36'h0, 36'h0, 1'b0, 3'd0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_cam_unit.md
TLB_CAM_UNIT -- requirements
Module: tlb_cam_unit

Interface
REQ-001 Parameter KEY_WIDTH, default 36, sets the key width in bits; keys are MSB-first [0:KEY_WIDTH-1].
REQ-002 Parameter ENTRIES, default 8, sets the number of CAM entries.
REQ-003 Parameter ADR_WIDTH, default 3, sets the entry address width; it SHALL equal log2(ENTRIES).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 patternA  input  KEY_WIDTH  lookup key for port A; also the write data.
REQ-007 patternB  input  KEY_WIDTH  lookup key for port B.
REQ-008 writeAdr  input  ADR_WIDTH  entry index written when wEnable=1.
REQ-009 wEnable  input  1  write enable.
REQ-010 matchAdrA  output  ADR_WIDTH  index of the matching entry for patternA.
REQ-011 matchAdrB  output  ADR_WIDTH  index of the matching entry for patternB.
REQ-012 mFoundA  output  1  patternA hit flag.
REQ-013 mFoundB  output  1  patternB hit flag.

Function
REQ-014 Storage SHALL be ENTRIES key registers of KEY_WIDTH bits, each with one valid bit.
REQ-015 At a rising clk edge with wEnable=1, key[writeAdr] SHALL take patternA and valid[writeAdr] SHALL be set to 1.
REQ-016 With wEnable=0 at the edge, no entry SHALL change.
REQ-017 Lookup SHALL be purely combinational and independent per port; A and B SHALL resolve in the same cycle with zero latency.
REQ-018 An entry SHALL match a port only when its valid bit is 1 and all KEY_WIDTH bits equal that port's pattern; partial matches are misses.
REQ-019 On a hit, mFoundX SHALL be 1 and matchAdrX SHALL be the matching index.
REQ-020 If several entries match, matchAdrX SHALL report the lowest index.
REQ-021 On a miss, mFoundX SHALL be 0 and matchAdrX SHALL be 0.
REQ-022 Write and lookup in the same cycle: outputs SHALL reflect the old contents until the edge, then the new contents immediately after it, with no bypass.
REQ-023 Duplicate keys are allowed; no uniqueness check is performed.
REQ-024 Both ports MAY look up the same key simultaneously and SHALL return identical results.

Reset
REQ-025 When rst=1, all valid bits SHALL clear immediately, without waiting for clk; key contents SHALL become 0.
REQ-026 While rst=1, writes SHALL be ignored, and mFoundA/B and matchAdrA/B SHALL be 0.
REQ-027 After reset, no pattern SHALL hit, including the all-zero pattern.
REQ-028 If rst asserts during a write cycle, the write SHALL be lost.

Configuration
REQ-029 Macro TLB_CAM_INVALIDATE_EN, when defined, SHALL add input iEnable (1 bit).
REQ-030 With TLB_CAM_INVALIDATE_EN defined, a rising edge with iEnable=1 SHALL clear valid[writeAdr].
REQ-031 With TLB_CAM_INVALIDATE_EN defined, if wEnable=1 and iEnable=1 in the same cycle, the write SHALL win.
REQ-032 With TLB_CAM_INVALIDATE_EN undefined, the iEnable port SHALL be absent and entries SHALL leave the valid state only through rst.

Verification
REQ-033 Reset, then patternA=0, patternB=0 -> mFoundA=mFoundB=0, matchAdrA=matchAdrB=0.
REQ-034 Write 0x001200120, 0x003400340, 0x005600560, 0x007800780, 0x009A009A0, 0x00BC00BC0, 0x00DE00DE0, 0x00FF00FF0 to entries 0..7; then patternA=0x005600560, patternB=0x003400340 -> matchAdrA=2, matchAdrB=1, both found=1.
REQ-035 After REQ-034, patternA=0x007800780, patternB=0x001200120 -> matchAdrA=3, matchAdrB=0, both found=1.
REQ-036 After REQ-034, patternA=0x000000780, patternB=0x001200000 -> mFoundA=mFoundB=0, matchAdrA=matchAdrB=0.
REQ-037 Write 0x0ABCDE123 to entries 5 and 2, then look it up on both ports -> matchAdrA=matchAdrB=2; assert rst mid-cycle -> both found=0 immediately.
REQ-038 With TLB_CAM_INVALIDATE_EN defined: invalidate entry 3, then look up 0x007800780 -> miss; write and invalidate entry 3 together -> hit at 3.
